// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the modulo counter family.
//   DIR_UP / DIR_DN : encodings of the direction input.
//   mod_params_ok() : legality check for WIDTH / MODULUS / RESET_VAL,
//                     evaluated at elaboration time by each counter variant.
// ---------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // MODULUS must lie in 2..2**WIDTH and RESET_VAL must be a reachable count.
    function automatic bit mod_params_ok(input int width,
                                         input longint modulus,
                                         input longint reset_val);
        longint max_mod;
        if (width < 1 || width > 31) begin
            return 1'b0;
        end
        max_mod = longint'(1) << width;
        return (modulus >= 2) && (modulus <= max_mod) &&
               (reset_val >= 0) && (reset_val < modulus);
    endfunction

endpackage

// File: rtl/m_mod_next.sv
// ---------------------------------------------------------------------------
// m_mod_next
// Combinational next-state logic of the modulo counter: next count value,
// wrap flag and load-clamp flag, given the current count and the controls.
// Ports:
//   i_q            current registered count
//   i_din          parallel load value
//   i_up           direction (DIR_UP / DIR_DN)
//   i_oneshot      1 = stop at the terminal value instead of wrapping
//   i_load         parallel load strobe (beats i_en)
//   i_en           count enable
//   o_q_next       next count value
//   o_wrap_next    a wrap happens on this edge
//   o_ld_err_next  an out-of-range load is being clamped on this edge
// ---------------------------------------------------------------------------
module m_mod_next
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_up,
    input  logic             i_oneshot,
    input  logic             i_load,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_q_next,
    output logic             o_wrap_next,
    output logic             o_ld_err_next
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic w_at_max;
    logic w_at_zero;

    // Terminal values are detected by explicit compares, so the full-range
    // case (MODULUS = 2**WIDTH) never depends on adder overflow.
    assign w_at_max  = (i_q == MAX_VAL);
    assign w_at_zero = (i_q == '0);

    always_comb begin
        o_q_next      = i_q;
        o_wrap_next   = 1'b0;
        o_ld_err_next = 1'b0;
        if (i_load) begin
            // Anything above MAX_VAL is out of range; clamp to the top count.
            if (i_din > MAX_VAL) begin
                o_q_next      = MAX_VAL;
                o_ld_err_next = 1'b1;
            end else begin
                o_q_next = i_din;
            end
        end else if (i_en) begin
            if (i_up == DIR_UP) begin
                if (w_at_max) begin
                    if (!i_oneshot) begin
                        o_q_next    = '0;
                        o_wrap_next = 1'b1;
                    end
                end else begin
                    o_q_next = i_q + 1'b1;
                end
            end else begin
                if (w_at_zero) begin
                    if (!i_oneshot) begin
                        o_q_next    = MAX_VAL;
                        o_wrap_next = 1'b1;
                    end
                end else begin
                    o_q_next = i_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/m_mod_counter.sv
// ---------------------------------------------------------------------------
// m_mod_counter
// Parametrised modulo-MODULUS up/down counter with enable, parallel load,
// one-shot (saturating) mode and a cascadable terminal-count output.
// Ports:
//   ck       clock, all state changes on its rising edge
//   nres     synchronous active-low reset (highest priority)
//   en       count enable
//   up       direction, 1 = increment, 0 = decrement
//   oneshot  1 = stop at the terminal value, 0 = wrap around
//   load     parallel load strobe (beats en)
//   din      load value; values >= MODULUS are clamped to MODULUS-1
//   q        registered count, always in 0..MODULUS-1
//   tc       combinational terminal count, drives the next stage's en
//   wrap     one-cycle pulse: a wrap happened on the previous edge
//   ld_err   one-cycle pulse: a load was clamped on the previous edge
// ---------------------------------------------------------------------------
module m_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             ck,
    input  logic             nres,
    input  logic             en,
    input  logic             up,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ld_err
);

    if (!mod_params_ok(WIDTH, longint'(MODULUS), longint'(RESET_VAL))) begin : g_bad_params
        $error("m_mod_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_ld_err;

    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_ld_err_next;

    m_mod_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .i_q           (r_q),
        .i_din         (din),
        .i_up          (up),
        .i_oneshot     (oneshot),
        .i_load        (load),
        .i_en          (en),
        .o_q_next      (w_q_next),
        .o_wrap_next   (w_wrap_next),
        .o_ld_err_next (w_ld_err_next)
    );

    always_ff @(posedge ck) begin
        if (!nres) begin
            r_q      <= RST_Q;
            r_wrap   <= 1'b0;
            r_ld_err <= 1'b0;
        end else begin
            r_q      <= w_q_next;
            r_wrap   <= w_wrap_next;
            r_ld_err <= w_ld_err_next;
        end
    end

    // Zero-latency terminal count: the next stage sees it in the same cycle.
    // Raised even in one-shot mode so a chained stage still advances.
    assign tc = en & ~load &
                (((up == DIR_UP) & (r_q == MAX_VAL)) |
                 ((up == DIR_DN) & (r_q == '0)));

    assign q      = r_q;
    assign wrap   = r_wrap;
    assign ld_err = r_ld_err;

endmodule

// File: doc/m_mod_counter.md
Name: m_mod_counter

Overview:
- Parametrised modulo-N up/down counter; the next generation of the team's 4-bit free-running counter.
- Adds:
  - generic width and modulus
  - direction control
  - count enable
  - parallel load
  - one-shot (saturating) mode
  - cascadable terminal-count output
  - registered wrap and load-error flags
- Used as timebase, divider and event counter; instances chain through `tc` → `en` for wide/BCD counting.

Parameters:
- WIDTH, 4, bit width of q and din.
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2..2**WIDTH; an elaboration check fails outside this range.
- RESET_VAL, 0, value of q after reset. Must be < MODULUS; an elaboration check fails otherwise.

Ports:
- ck  in  1  clock; all state updates on posedge ck.
- nres  in  1  synchronous reset, active-low; one clock, no other clock domain.
- en  in  1  count enable.
- up  in  1  direction; 1 = increment, 0 = decrement.
- oneshot  in  1  1 = stop at terminal value; 0 = wrap.
- load  in  1  parallel load strobe.
- din  in  WIDTH  load value.
- q  out  WIDTH  registered count.
- tc  out  1  combinational terminal count, for cascading.
- wrap  out  1  registered one-cycle pulse: a wrap occurred on the previous edge.
- ld_err  out  1  registered one-cycle pulse: an out-of-range load was clamped on the previous edge.

Behaviour:
- Reset (sampled at posedge ck with nres=0): q=RESET_VAL, wrap=0, ld_err=0. Reset has priority over everything.
- Reset mid-operation overrides load/en in that same cycle. There is no asynchronous path; q holds until the edge.
- Priority per edge: nres=0 > load=1 > en=1 > hold.
- Load:
  - din < MODULUS: q<=din, ld_err<=0.
  - din >= MODULUS: q<=MODULUS-1, ld_err<=1.
  - wrap<=0 on any load.
  - Load ignores en, up and oneshot.
- Count (en=1, load=0):
  - up=1, q<MODULUS-1: q<=q+1.
  - up=1, q==MODULUS-1: q<=0 and wrap<=1 if oneshot=0; q holds and wrap<=0 if oneshot=1.
  - up=0, q>0: q<=q-1.
  - up=0, q==0: q<=MODULUS-1 and wrap<=1 if oneshot=0; q holds and wrap<=0 if oneshot=1.
- Hold (en=0, load=0): q unchanged, wrap<=0, ld_err<=0.
- wrap and ld_err are single-cycle pulses. They deassert on the next edge unless re-triggered; a continuous wrap every cycle is legal when MODULUS=2.
- tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)):
  - purely combinational from registered q and inputs;
  - asserted regardless of oneshot;
  - zero latency, so the next stage's en sees it in the same cycle.
- Arithmetic: comparisons use WIDTH-bit unsigned. When MODULUS=2**WIDTH, +1/-1 wrap naturally, but the explicit compare path is still used; there is no reliance on overflow.
- Direction change takes effect on the next edge, with no dead cycle.
- q never holds a value >= MODULUS in any reachable state.

Decomposition:
- Shared package `counter_pkg`:
  - mode encodings (`DIR_UP`=1, `DIR_DN`=0);
  - elaboration-check helper function for the MODULUS/RESET_VAL legality;
  - used by future counter variants.
- One natural sub-module, `m_mod_next`: combinational next-value/wrap/clamp logic, given q, din, up, oneshot, load, en. It returns the next q, the wrap_next and ld_err_next. The top holds the three registers and the tc expression.

Test Plan (WIDTH=4, MODULUS=10, RESET_VAL=0 unless stated):
- Reset: run counting to q=7, drop nres for one edge with en=1 and load=1 → q=0, wrap=0, ld_err=0 at the next edge; counting resumes 1,2,… after nres=1.
- Up-wrap: en=1, up=1, oneshot=0 from q=0 → q sequence 0..9 then 0. tc=1 only while q=9. wrap=1 for exactly the one cycle after the 9→0 edge.
- Down/oneshot:
  - load din=2, then en=1, up=0, oneshot=1 → q 2,1,0,0,0; tc=1 while q=0; wrap stays 0.
  - switch oneshot=0 → the next edge gives q=9, and wrap pulses.
- Load clamp: load=1, din=12 (en=1 simultaneously) → q=9, ld_err=1 for one cycle. Then load din=5 → q=5, ld_err=0.
- Cascade: two instances as a BCD pair, low.tc→high.en, counting up from 00 → sequence 08,09,10. High increments only on the edge where low is 9. Reaching 99 then gives 00, with both wrap flags pulsing together.
- Full-range: WIDTH=4, MODULUS=16, RESET_VAL=15 → reset gives q=15; one up edge gives q=0 with wrap=1; down from 0 gives 15.
